// File: rtl/demultiplexador_buffer_pkg.sv
// Shared constants and width helpers for the two-channel demux buffer.
package demultiplexador_buffer_pkg;

   localparam int DATA_BITS_DEF  = 32;
   localparam int FIFO_DEPTH_DEF = 4;

   // Pointer width: log2 of the channel depth (depth is a power of two, >= 2).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Count width: one extra bit so a full channel (count == depth) is representable.
   function automatic int cnt_width(input int depth);
      return ptr_width(depth) + 1;
   endfunction

   localparam int PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);
   localparam int CNT_W_DEF = cnt_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/demultiplexador_buffer_fila_canal.sv
// One output channel: circular FIFO with occupancy count, full/empty flags
// and a valid/ready output port. Pop is qualified here; push is pre-steered.
module fila_canal
   import demultiplexador_buffer_pkg::*;
#(
   parameter  int DATA_BITS  = DATA_BITS_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W      = ptr_width(FIFO_DEPTH),
   localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop_ready,
   output logic                 out_valid,
   output logic [DATA_BITS-1:0] out_data,
   output logic [CNT_W-1:0]     count,
   output logic                 full
);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // A full channel refuses the word even if it is being popped this edge;
   // an empty channel ignores the consumer's ready.
   assign do_push = push && !full;
   assign do_pop  = out_valid && pop_ready;

   // Storage write: only the entry under the write pointer changes.
   // NOTE: the data array has no reset; emptiness is carried by count alone,
   // so clearing storage would only cost flops and reset fan-out.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy state; pointers wrap naturally at FIFO_DEPTH.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/demultiplexador_buffer.sv
// Two-way demultiplexer feeding two independent buffered output channels.
// The top only steers the upstream word and muxes back the selected ready.
module demultiplexador_buffer
   import demultiplexador_buffer_pkg::*;
#(
   parameter  int DATA_BITS  = DATA_BITS_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 selector,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 out0_valid,
   output logic [DATA_BITS-1:0] out0_data,
   input  logic                 out0_ready,
   output logic                 out1_valid,
   output logic [DATA_BITS-1:0] out1_data,
   input  logic                 out1_ready,
   output logic [CNT_W-1:0]     count0,
   output logic [CNT_W-1:0]     count1
);

   logic full0;
   logic full1;
   logic push0;
   logic push1;

   // Ready follows the addressed channel only; push goes to that channel only.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      in_ready = 1'b0;
      push0    = 1'b0;
      push1    = 1'b0;
      in_ready = selector ? !full1 : !full0;
      push0    = in_valid && in_ready && !selector;
      push1    = in_valid && in_ready &&  selector;
   end

   fila_canal #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_canal0 (
      .clock     (clock),
      .reset     (reset),
      .push      (push0),
      .push_data (in_data),
      .pop_ready (out0_ready),
      .out_valid (out0_valid),
      .out_data  (out0_data),
      .count     (count0),
      .full      (full0)
   );

   fila_canal #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_canal1 (
      .clock     (clock),
      .reset     (reset),
      .push      (push1),
      .push_data (in_data),
      .pop_ready (out1_ready),
      .out_valid (out1_valid),
      .out_data  (out1_data),
      .count     (count1),
      .full      (full1)
   );

endmodule

// File: tb/tb_demultiplexador_buffer.sv
// Scoreboard bench: the driver queues expected words per channel, a monitor
// compares each word as the DUT hands it off; status is checked directly.
module tb_demultiplexador_buffer;

   localparam int DW = 32;
   localparam int CW = 3;

   logic          clock;
   logic          reset;
   logic          selector;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out0_valid;
   logic [DW-1:0] out0_data;
   logic          out0_ready;
   logic          out1_valid;
   logic [DW-1:0] out1_data;
   logic          out1_ready;
   logic [CW-1:0] count0;
   logic [CW-1:0] count1;

   logic [DW-1:0] exp0 [$];
   logic [DW-1:0] exp1 [$];
   int n_compared   = 0;
   int n_mismatched = 0;

   demultiplexador_buffer #(
      .DATA_BITS  (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .selector   (selector),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out0_valid (out0_valid),
      .out0_data  (out0_data),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_data  (out1_data),
      .out1_ready (out1_ready),
      .count0     (count0),
      .count1     (count1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [DW-1:0] actual,
                        input logic [DW-1:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: a handshake seen mid-cycle completes on the next rising edge.
   always @(negedge clock) begin
      if (!reset && out0_valid && out0_ready) begin
         if (exp0.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL ch0 unexpected word: got 0x%0h, expected none", out0_data);
         end else begin
            check("ch0 order", out0_data, exp0.pop_front());
         end
      end
      if (!reset && out1_valid && out1_ready) begin
         if (exp1.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL ch1 unexpected word: got 0x%0h, expected none", out1_data);
         end else begin
            check("ch1 order", out1_data, exp1.pop_front());
         end
      end
   end

   initial begin
      reset      = 1'b1;
      selector   = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("reset count0", 32'(count0), 32'd0);
      check("reset count1", 32'(count1), 32'd0);
      check("reset out0_valid", 32'(out0_valid), 32'd0);
      check("reset out1_valid", 32'(out1_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);

      // Two words to channel 0, first one accepted on the first edge after reset
      selector = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hA1; exp0.push_back(32'hA1);
      tick();
      check("latency out0_valid", 32'(out0_valid), 32'd1);
      check("latency count0", 32'(count0), 32'd1);
      in_data  = 32'hA2; exp0.push_back(32'hA2);
      tick();
      in_valid = 1'b0;
      check("ch0 count0", 32'(count0), 32'd2);
      check("ch0 count1", 32'(count1), 32'd0);
      check("ch0 head", out0_data, 32'hA1);
      check("ch0 out1_valid", 32'(out1_valid), 32'd0);
      tick();
      check("ch0 head stable", out0_data, 32'hA1);

      // Fill channel 1; full non-selected channel must not stall channel 0
      selector = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'hB0 + 32'(i);
         exp1.push_back(in_data);
         tick();
      end
      in_valid = 1'b0;
      check("ch1 full count1", 32'(count1), 32'd4);
      check("ch1 full in_ready", 32'(in_ready), 32'd0);
      selector = 1'b0;
      #1;
      check("sel0 in_ready", 32'(in_ready), 32'd1);

      // Fill channel 0, then offer a word while popping: no pass-through
      in_valid = 1'b1;
      in_data  = 32'hA3; exp0.push_back(32'hA3);
      tick();
      in_data  = 32'hA4; exp0.push_back(32'hA4);
      tick();
      in_valid = 1'b0;
      check("ch0 full count0", 32'(count0), 32'd4);
      check("ch0 full in_ready", 32'(in_ready), 32'd0);
      in_valid   = 1'b1;
      in_data    = 32'hEE;
      out0_ready = 1'b1;
      #1;
      check("full pop in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      check("full pop count0", 32'(count0), 32'd3);
      check("after pop in_ready", 32'(in_ready), 32'd1);

      // Drain channel 1 plus one extra cycle of ready while empty
      out1_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      out1_ready = 1'b0;
      check("ch1 drained count1", 32'(count1), 32'd0);
      check("ch1 drained valid", 32'(out1_valid), 32'd0);

      // Simultaneous push/pop at count 2 across several pointer wraps
      out0_ready = 1'b1;
      tick();
      check("pre push-pop count0", 32'(count0), 32'd2);
      selector = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 32'hC0 + 32'(i);
         exp0.push_back(in_data);
         tick();
         check("push-pop count0", 32'(count0), 32'd2);
      end
      in_valid = 1'b0;
      tick();
      tick();
      out0_ready = 1'b0;
      check("wrap drained count0", 32'(count0), 32'd0);
      check("wrap drained valid", 32'(out0_valid), 32'd0);

      // Alternating selector every cycle
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         selector = i[0];
         in_data  = 32'(i);
         if (i[0]) exp1.push_back(in_data);
         else      exp0.push_back(in_data);
         tick();
      end
      in_valid = 1'b0;
      selector = 1'b0;
      check("alt count0", 32'(count0), 32'd4);
      check("alt count1", 32'(count1), 32'd4);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      check("alt drained count0", 32'(count0), 32'd0);
      check("alt drained count1", 32'(count1), 32'd0);

      // Reset mid-cycle with both channels holding data
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         selector = i[0];
         in_data  = 32'hD0 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      selector = 1'b1;
      check("pre-reset count0", 32'(count0), 32'd2);
      check("pre-reset count1", 32'(count1), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check("async reset count0", 32'(count0), 32'd0);
      check("async reset count1", 32'(count1), 32'd0);
      check("async reset out0_valid", 32'(out0_valid), 32'd0);
      check("async reset out1_valid", 32'(out1_valid), 32'd0);
      check("async reset in_ready", 32'(in_ready), 32'd1);
      tick();
      reset = 1'b0;

      // First edge after reset accepts a word
      in_valid = 1'b1;
      in_data  = 32'hF1; exp1.push_back(32'hF1);
      tick();
      in_valid = 1'b0;
      check("post-reset count1", 32'(count1), 32'd1);
      check("post-reset count0", 32'(count0), 32'd0);
      out1_ready = 1'b1;
      tick();
      out1_ready = 1'b0;
      check("post-reset drained", 32'(count1), 32'd0);

      check("ch0 leftover expected", 32'(exp0.size()), 32'd0);
      check("ch1 leftover expected", 32'(exp1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/demultiplexador_buffer.md
DEMULTIPLEXADOR_BUFFER -- requirements
Module: demultiplexador_buffer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, width of every data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per output channel, power of two, minimum 2.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port selector  input  1  destination of the offered word: 0 = channel 0, 1 = channel 1.
REQ-006 SHALL have port in_valid  input  1  upstream word offered.
REQ-007 SHALL have port in_data  input  DATA_BITS  upstream word.
REQ-008 SHALL have port in_ready  output  1  selected channel can accept the word this cycle.
REQ-009 SHALL have port out0_valid  output  1  channel 0 head word available.
REQ-010 SHALL have port out0_data  output  DATA_BITS  channel 0 head word.
REQ-011 SHALL have port out0_ready  input  1  channel 0 consumer accepts head word.
REQ-012 SHALL have ports out1_valid, out1_data, out1_ready, identical to REQ-009..011, for channel 1.
REQ-013 SHALL have ports count0, count1  output  log2(FIFO_DEPTH)+1  occupancy of channel 0 / channel 1.

Function
REQ-014 SHALL transfer a word on a rising edge iff in_valid and in_ready are both high; selector is sampled on that same edge.
REQ-015 SHALL drive in_ready = NOT full(channel addressed by current selector), purely combinationally, independent of in_valid.
REQ-016 SHALL never write the non-selected channel; a full non-selected channel does not stall input.
REQ-017 SHALL keep each channel FIFO-ordered; words leave in the order they entered that channel.
REQ-018 SHALL assert outN_valid = (countN != 0); outN_data = head entry, stable while outN_valid high and outN_ready low.
REQ-019 SHALL pop channel N on an edge iff outN_valid and outN_ready are high.
REQ-020 SHALL have 1-cycle latency: word pushed into empty channel on edge k is valid after edge k, no same-cycle bypass.
REQ-021 SHALL, on simultaneous push and pop of one channel, leave countN unchanged and advance both pointers.
REQ-022 SHALL, when full, deassert in_ready for that channel even if the same-cycle pop is asserted (no pass-through).
REQ-023 SHALL ignore outN_ready while channel N is empty; count never underflows.
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH; full = count == FIFO_DEPTH, empty = count == 0.
REQ-025 SHALL allow selector to change every cycle; channels operate fully independently on output side.
REQ-026 SHALL leave outN_data undefined-but-stable content irrelevant when outN_valid is low (bench must not check it).

Reset
REQ-027 SHALL, on reset assertion, immediately clear pointers and counts: count0 = count1 = 0, out0_valid = out1_valid = 0, in_ready = 1.
REQ-028 SHALL discard all buffered words on reset, including reset mid-transfer; storage array need not be cleared.
REQ-029 SHALL accept a new word on the first rising edge after reset deassertion.

Structure
REQ-030 SHALL place FIFO_DEPTH default, pointer width log2(FIFO_DEPTH) and count width constants in the shared package/header.
REQ-031 SHALL implement each channel as one sub-module fila_canal (storage, pointers, count, full/empty), instantiated twice.
REQ-032 SHALL keep top-level logic limited to push steering (selector AND in_valid AND in_ready) and in_ready mux.

Verification
REQ-033 SHALL cover: reset, then selector=0, push 0xA1,0xA2 with out0_ready=0 -> count0=2, count1=0, out0_data=0xA1, out1_valid=0.
REQ-034 SHALL cover: selector=1, push 4 words with out1_ready=0 -> count1=4, in_ready=0 while selector=1, in_ready=1 when selector=0.
REQ-035 SHALL cover: channel 0 full, in_valid=1, out0_ready=1, selector=0 -> no push that cycle, count0 goes 4->3, next cycle in_ready=1.
REQ-036 SHALL cover: count0=2, push and pop same edge -> count0 stays 2, output order preserved across pointer wrap after 10 words.
REQ-037 SHALL cover: alternating selector per cycle, 8 words 0x00..0x07 -> channel 0 emits 0x00,0x02,0x04,0x06; channel 1 emits 0x01,0x03,0x05,0x07.
REQ-038 SHALL cover: reset asserted mid-cycle with both channels holding data -> counts 0 and valids low before next clock edge.
